sisc_dmem_resp: RTL and testbench

Data-memory responder for the SISC CPU. It is the memory-side end of the control unit's `mem` stage: it accepts a single-word load or store request, waits a fixed number of cycles to model memory latency, commits the write or returns the read word, and signals completion with a one-cycle acknowledge. It sits between the datapath's address/store-data mux and the load writeback path.

---
 rtl/sisc_pkg.sv | 18 +
 rtl/sisc_dmem_resp_if.sv | 19 +
 rtl/sisc_dmem_array.sv | 41 ++++
 rtl/sisc_dmem_resp.sv | 132 +++++++++++++
 tb/tb_sisc_dmem_resp.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: state encoding of the data-memory responder and
// default bus widths used by the control unit, datapath and memory side.
package sisc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } dmem_state_e;

endpackage

// File: rtl/sisc_dmem_resp_if.sv
// Request/response bus between the mem stage and the data-memory responder.
interface sisc_dmem_resp_if
  import sisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/sisc_dmem_array.sv
// Single-port synchronous RAM with a registered read port; the read register
// can be cleared so an out-of-range access returns zero.
module sisc_dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Registered read data, cleared by reset or an out-of-range access.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      rdata_r <= '0;
    end else if (clr) begin
      rdata_r <= '0;
    end else if (en && !we) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sisc_dmem_resp.sv
// Data-memory responder: captures one load/store, waits LATENCY cycles,
// executes it on the RESP-entry edge and pulses ack for one cycle.
module sisc_dmem_resp
  import sisc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_f,
  sisc_dmem_resp_if.slave  bus
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        LAT_C   = 4'(LATENCY);

  dmem_state_e       state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ack_r;
  logic              err_r;
  logic              busy_r;

  logic              fire_s;
  logic              op_we_s;
  logic [ADDR_W-1:0] op_addr_s;
  logic [DATA_W-1:0] op_wdata_s;
  logic              in_range_s;

  // With zero latency the live request executes on its own capture edge.
  always_comb begin
    fire_s     = 1'b0;
    op_we_s    = we_r;
    op_addr_s  = addr_r;
    op_wdata_s = wdata_r;
    if (state_r == S_IDLE) begin
      op_we_s    = bus.we;
      op_addr_s  = bus.addr;
      op_wdata_s = bus.wdata;
      fire_s     = bus.req && (LAT_C == 4'd0);
    end else if (state_r == S_WAIT) begin
      fire_s = (cnt_r == 4'd1);
    end else begin
      fire_s = 1'b0;
    end
    in_range_s = ({1'b0, op_addr_s} < DEPTH_C);
  end

  // Control FSM with capture registers, latency counter and registered status.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (bus.req) begin
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            busy_r  <= 1'b1;
            if (LAT_C == 4'd0) begin
              state_r <= S_RESP;
              ack_r   <= 1'b1;
              err_r   <= !in_range_s;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= LAT_C;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= S_RESP;
            ack_r   <= 1'b1;
            err_r   <= !in_range_s;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  sisc_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_f (rst_f),
    .en    (fire_s && in_range_s),
    .we    (op_we_s),
    .clr   (fire_s && !in_range_s),
    .idx   (op_addr_s[IDX_W-1:0]),
    .wdata (op_wdata_s),
    .rdata (bus.rdata)
  );

  assign bus.ack  = ack_r;
  assign bus.err  = err_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_sisc_dmem_resp.sv
// Bench for sisc_dmem_resp: a LATENCY=0 and a LATENCY=2 instance against a
// transaction-level memory model, directed cases followed by random traffic.
module tb_sisc_dmem_resp;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  sisc_dmem_resp_if bus0 ();
  sisc_dmem_resp_if bus2 ();

  sisc_dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst_f(rst_f), .bus(bus0.slave));
  sisc_dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut2 (
    .clk(clk), .rst_f(rst_f), .bus(bus2.slave));

  // index 0 drives the LATENCY=0 instance, index 1 the LATENCY=2 instance
  logic        req_v   [2];
  logic        we_v    [2];
  logic [15:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        ack_w   [2];
  logic        err_w   [2];
  logic        busy_w  [2];
  logic [31:0] rdata_w [2];

  assign bus0.req = req_v[0];  assign bus0.we = we_v[0];
  assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
  assign bus2.req = req_v[1];  assign bus2.we = we_v[1];
  assign bus2.addr = addr_v[1]; assign bus2.wdata = wdata_v[1];
  assign ack_w[0] = bus0.ack;  assign err_w[0] = bus0.err;
  assign busy_w[0] = bus0.busy; assign rdata_w[0] = bus0.rdata;
  assign ack_w[1] = bus2.ack;  assign err_w[1] = bus2.err;
  assign busy_w[1] = bus2.busy; assign rdata_w[1] = bus2.rdata;

  int total = 0;
  int bad = 0;

  // reference model: memory contents and the last read result per instance
  logic [31:0] mem_m0 [int];
  logic [31:0] mem_m1 [int];
  logic [31:0] rd_m [2];
  bit          rd_known [2];
  int          lat_m [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rd_m[0] = 32'h0; rd_m[1] = 32'h0;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;
  endtask

  // apply the memory rules of one transaction to the model
  task automatic model_apply(input int d, input bit w, input logic [15:0] a, input logic [31:0] wd);
    int ai;
    ai = int'(a);
    if (ai >= 256) begin
      rd_m[d] = 32'h0;
      rd_known[d] = 1'b1;
    end else if (w) begin
      if (d == 0) mem_m0[ai] = wd; else mem_m1[ai] = wd;
    end else if (d == 0) begin
      rd_known[d] = mem_m0.exists(ai);
      if (rd_known[d]) rd_m[d] = mem_m0[ai];
    end else begin
      rd_known[d] = mem_m1.exists(ai);
      if (rd_known[d]) rd_m[d] = mem_m1[ai];
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ack"}, {31'h0, ack_w[d]}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy_w[d]}, 32'h0);
      chk({tag, "_err"}, {31'h0, err_w[d]}, 32'h0);
      chk({tag, "_rdata"}, rdata_w[d], 32'h0);
    end
  endtask

  // one full transaction with cycle-by-cycle ack/err/busy/rdata checks
  task automatic txn(input int d, input bit w, input logic [15:0] a, input logic [31:0] wd, input string tag);
    bit oor;
    oor = (int'(a) >= 256);
    @(negedge clk);
    chk({tag, "_idle_before"}, {31'h0, busy_w[d]}, 32'h0);
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
    @(posedge clk); #1;
    req_v[d] = 1'b0;
    model_apply(d, w, a, wd);
    for (int k = 0; k <= lat_m[d] + 1; k++) begin
      if (k == lat_m[d]) begin
        chk({tag, "_ack"}, {31'h0, ack_w[d]}, 32'h1);
        chk({tag, "_err"}, {31'h0, err_w[d]}, {31'h0, oor});
        if (rd_known[d]) chk({tag, "_rdata"}, rdata_w[d], rd_m[d]);
        chk({tag, "_busy_resp"}, {31'h0, busy_w[d]}, 32'h1);
      end else if (k < lat_m[d]) begin
        chk({tag, "_noack"}, {31'h0, ack_w[d]}, 32'h0);
        chk({tag, "_busy_wait"}, {31'h0, busy_w[d]}, 32'h1);
      end else begin
        chk({tag, "_ack_done"}, {31'h0, ack_w[d]}, 32'h0);
        chk({tag, "_err_done"}, {31'h0, err_w[d]}, 32'h0);
        chk({tag, "_busy_done"}, {31'h0, busy_w[d]}, 32'h0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acks;
    lat_m[0] = 0; lat_m[1] = 2;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = 16'h0; wdata_v[d] = 32'h0;
    end
    model_reset();

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("reset");
    end
    @(negedge clk); rst_f = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");

    // store then load at LATENCY=2
    txn(1, 1'b1, 16'd5, 32'hDEADBEEF, "st5_l2");
    txn(1, 1'b0, 16'd5, 32'h0, "ld5_l2");
    // store then load at LATENCY=0
    txn(0, 1'b1, 16'd0, 32'h12345678, "st0_l0");
    txn(0, 1'b0, 16'd0, 32'h0, "ld0_l0");
    // last legal word and first illegal address
    txn(1, 1'b1, 16'd255, 32'hCAFE00FF, "st255");
    txn(1, 1'b0, 16'd255, 32'h0, "ld255");
    txn(1, 1'b1, 16'd0, 32'h0BADF00D, "st0_l2");
    txn(1, 1'b0, 16'h0100, 32'h0, "ld_oor");
    txn(1, 1'b1, 16'h0100, 32'hFFFFFFFF, "st_oor");
    txn(1, 1'b0, 16'd0, 32'h0, "ld0_after_oor");
    txn(0, 1'b0, 16'hFFFF, 32'h0, "ld_oor_l0");

    // busy rejection: a load of 7 held during a store to 3 is ignored
    txn(1, 1'b1, 16'd7, 32'h77777777, "st7");
    txn(1, 1'b0, 16'd5, 32'h0, "ld5_again");
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd3; wdata_v[1] = 32'h33330003;
    @(posedge clk); #1;
    model_apply(1, 1'b1, 16'd3, 32'h33330003);
    we_v[1] = 1'b0; addr_v[1] = 16'd7;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      if (ack_w[1] === 1'b1) acks++;
      @(posedge clk); #1;
    end
    req_v[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ack_w[1] === 1'b1) acks++;
      @(posedge clk); #1;
    end
    chk("busy_rej_acks", acks, 32'd1);
    chk("busy_rej_rdata", rdata_w[1], rd_m[1]);
    txn(1, 1'b0, 16'd3, 32'h0, "ld3");

    // reset during WAIT discards the pending store
    txn(1, 1'b1, 16'd9, 32'h0, "pre9");
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd9; wdata_v[1] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    chk("midrst_busy_before", {31'h0, busy_w[1]}, 32'h1);
    @(posedge clk); #1;
    rst_f = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy_w[1]}, 32'h0);
    chk("midrst_ack", {31'h0, ack_w[1]}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle("midrst_hold");
    @(negedge clk); rst_f = 1'b1;
    txn(1, 1'b0, 16'd9, 32'h0, "ld9_after_rst");

    // random traffic with in-range, boundary and out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      int d;
      bit w;
      logic [15:0] a;
      d = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(250, 262));
      else a = 16'($urandom_range(0, 15));
      txn(d, w, a, $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
